lcd_timing_driver: RTL and testbench

Panel-side timing generator for the parallel RGB LCD. It produces HSYNC, VSYNC and DE for a 24-bit RGB panel. It presents pixel_xpos/pixel_ypos one cycle early to the upstream pixel generator, which registers its response. The returned pixel_data is forwarded to the panel aligned with DE. It also exports the active resolution (h_disp/v_disp) that the pixel generator uses to lay out its pattern.

---
 rtl/lcd_pkg.sv | 51 +++++
 rtl/lcd_axis_counter.sv | 77 +++++++
 rtl/lcd_timing_driver.sv | 115 +++++++++++
 tb/tb_lcd_timing_driver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the parallel RGB LCD path.
//   COORD_W      - width of pixel coordinates and timing counters
//   lcd_timing_t - one panel's horizontal/vertical timing set
//   TIM_*        - timing sets for the 480x272, 800x480 and 1024x600 panels
//   WHITE..BLUE  - RGB888 colour constants shared with the pixel generator
//   span()       - total length of one axis (sync+back+disp+front)
package lcd_pkg;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [23:0]        rgb_t;

  typedef struct packed {
    coord_t h_sync;
    coord_t h_back;
    coord_t h_disp;
    coord_t h_front;
    coord_t v_sync;
    coord_t v_back;
    coord_t v_disp;
    coord_t v_front;
  } lcd_timing_t;

  localparam lcd_timing_t TIM_480X272 = '{
    h_sync: 11'd41,  h_back: 11'd2,   h_disp: 11'd480,  h_front: 11'd2,
    v_sync: 11'd10,  v_back: 11'd2,   v_disp: 11'd272,  v_front: 11'd2
  };

  localparam lcd_timing_t TIM_800X480 = '{
    h_sync: 11'd128, h_back: 11'd88,  h_disp: 11'd800,  h_front: 11'd40,
    v_sync: 11'd2,   v_back: 11'd33,  v_disp: 11'd480,  v_front: 11'd10
  };

  localparam lcd_timing_t TIM_1024X600 = '{
    h_sync: 11'd20,  h_back: 11'd140, h_disp: 11'd1024, h_front: 11'd160,
    v_sync: 11'd3,   v_back: 11'd20,  v_disp: 11'd600,  v_front: 11'd12
  };

  localparam rgb_t WHITE = 24'hFF_FF_FF;
  localparam rgb_t BLACK = 24'h00_00_00;
  localparam rgb_t RED   = 24'hFF_00_00;
  localparam rgb_t GREEN = 24'h00_FF_00;
  localparam rgb_t BLUE  = 24'h00_00_FF;

  function automatic int span(input int sync_w, input int back_w,
                              input int disp_w, input int front_w);
    return sync_w + back_w + disp_w + front_w;
  endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// lcd_axis_counter: one timing axis (horizontal or vertical).
// Holds a wrapping position counter and decodes the sync, display and
// request windows from it. The request window is the display window
// shifted LEAD positions earlier, so a registered upstream source can
// answer in time.
// Ports:
//   lcd_pclk, rst_n - pixel clock, async active-low reset
//   adv_i           - advance the counter this cycle
//   cnt_o           - current position
//   wrap_o          - counter is at its last position and advancing
//   sync_o          - position inside the sync pulse
//   act_o           - position inside the display window
//   req_o           - position inside the request window
//   pos_o           - offset inside the request window, else 0
module lcd_axis_counter
  import lcd_pkg::*;
#(
  parameter int SYNC  = 41,
  parameter int BACK  = 2,
  parameter int DISP  = 480,
  parameter int FRONT = 2,
  parameter int LEAD  = 0
) (
  input  logic               lcd_pclk,
  input  logic               rst_n,
  input  logic               adv_i,
  output logic [COORD_W-1:0] cnt_o,
  output logic               wrap_o,
  output logic               sync_o,
  output logic               act_o,
  output logic               req_o,
  output logic [COORD_W-1:0] pos_o
);

  localparam int TOTAL = span(SYNC, BACK, DISP, FRONT);
  localparam int START = SYNC + BACK;

  localparam coord_t LAST     = coord_t'(TOTAL - 1);
  localparam coord_t SYNC_END = coord_t'(SYNC);
  localparam coord_t ACT_BEG  = coord_t'(START);
  localparam coord_t ACT_END  = coord_t'(START + DISP);
  localparam coord_t REQ_BEG  = coord_t'(START - LEAD);
  localparam coord_t REQ_END  = coord_t'(START + DISP - LEAD);
  localparam coord_t ONE      = coord_t'(1);

  if (START < LEAD) begin : g_bad_lead
    $error("lcd_axis_counter: SYNC+BACK must be at least LEAD");
  end
  if (DISP < 1) begin : g_bad_disp
    $error("lcd_axis_counter: DISP must be at least 1");
  end
  if (TOTAL > (2 ** COORD_W)) begin : g_bad_total
    $error("lcd_axis_counter: axis total does not fit COORD_W");
  end

  coord_t cnt_q, cnt_d;

  assign wrap_o = adv_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (wrap_o)     cnt_d = '0;
    else if (adv_i) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign sync_o = (cnt_q < SYNC_END);
  assign act_o  = (cnt_q >= ACT_BEG) && (cnt_q < ACT_END);
  assign req_o  = (cnt_q >= REQ_BEG) && (cnt_q < REQ_END);
  assign pos_o  = req_o ? (cnt_q - REQ_BEG) : '0;

endmodule

// File: rtl/lcd_timing_driver.sv
// lcd_timing_driver: HSYNC/VSYNC/DE generator for a 24-bit parallel RGB
// panel. Coordinates are requested one cycle ahead of DE; the upstream
// generator registers its answer, so pixel_data_i lines up with DE.
// Ports:
//   lcd_pclk, rst_n          - pixel clock, async active-low reset
//   pixel_data_i             - RGB888 from the pixel generator
//   pixel_xpos_o/pixel_ypos_o - requested column/row (0 outside requests)
//   data_req_o               - coordinates valid this cycle
//   h_disp_o/v_disp_o        - active resolution constants
//   lcd_hs_o/lcd_vs_o        - syncs, active level SYNC_POL
//   lcd_de_o/lcd_rgb_o       - data enable and panel pixel bus
//   lcd_bl_o                 - backlight enable
//   frame_start_o            - one-cycle pulse at the first frame position
module lcd_timing_driver
  import lcd_pkg::*;
#(
  parameter int H_SYNC   = int'(TIM_480X272.h_sync),
  parameter int H_BACK   = int'(TIM_480X272.h_back),
  parameter int H_DISP   = int'(TIM_480X272.h_disp),
  parameter int H_FRONT  = int'(TIM_480X272.h_front),
  parameter int V_SYNC   = int'(TIM_480X272.v_sync),
  parameter int V_BACK   = int'(TIM_480X272.v_back),
  parameter int V_DISP   = int'(TIM_480X272.v_disp),
  parameter int V_FRONT  = int'(TIM_480X272.v_front),
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                lcd_pclk,
  input  logic                rst_n,
  input  logic [23:0]         pixel_data_i,
  output logic [COORD_W-1:0]  pixel_xpos_o,
  output logic [COORD_W-1:0]  pixel_ypos_o,
  output logic                data_req_o,
  output logic [COORD_W-1:0]  h_disp_o,
  output logic [COORD_W-1:0]  v_disp_o,
  output logic                lcd_hs_o,
  output logic                lcd_vs_o,
  output logic                lcd_de_o,
  output logic [23:0]         lcd_rgb_o,
  output logic                lcd_bl_o,
  output logic                frame_start_o
);

  // The one-cycle request lead needs at least one blank column before DE.
  if (H_SYNC + H_BACK < 1) begin : g_bad_ha
    $error("lcd_timing_driver: H_SYNC+H_BACK must be at least 1");
  end

  // run_q stays low for one cycle after reset release, so every restart
  // shows a blank cycle and then begins cleanly at h=0, v=0.
  logic run_q;

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  coord_t h_cnt, v_cnt, h_pos, v_pos;
  logic   h_wrap, h_sync, h_act, h_req;
  logic   v_wrap_unused, v_sync, v_act, v_req;

  lcd_axis_counter #(
    .SYNC (H_SYNC),
    .BACK (H_BACK),
    .DISP (H_DISP),
    .FRONT(H_FRONT),
    .LEAD (1)
  ) u_h (
    .lcd_pclk(lcd_pclk),
    .rst_n   (rst_n),
    .adv_i   (run_q),
    .cnt_o   (h_cnt),
    .wrap_o  (h_wrap),
    .sync_o  (h_sync),
    .act_o   (h_act),
    .req_o   (h_req),
    .pos_o   (h_pos)
  );

  // Rows do not lead: the request and display row windows coincide.
  lcd_axis_counter #(
    .SYNC (V_SYNC),
    .BACK (V_BACK),
    .DISP (V_DISP),
    .FRONT(V_FRONT),
    .LEAD (0)
  ) u_v (
    .lcd_pclk(lcd_pclk),
    .rst_n   (rst_n),
    .adv_i   (h_wrap),
    .cnt_o   (v_cnt),
    .wrap_o  (v_wrap_unused),
    .sync_o  (v_sync),
    .act_o   (v_act),
    .req_o   (v_req),
    .pos_o   (v_pos)
  );

  logic de, req;

  assign de  = run_q && h_act && v_act;
  assign req = run_q && h_req && v_req;

  assign h_disp_o      = coord_t'(H_DISP);
  assign v_disp_o      = coord_t'(V_DISP);
  assign lcd_bl_o      = run_q;
  assign lcd_hs_o      = (run_q && h_sync) ? SYNC_POL : ~SYNC_POL;
  assign lcd_vs_o      = (run_q && v_sync) ? SYNC_POL : ~SYNC_POL;
  assign lcd_de_o      = de;
  assign data_req_o    = req;
  assign pixel_xpos_o  = req ? h_pos : '0;
  assign pixel_ypos_o  = req ? v_pos : '0;
  assign lcd_rgb_o     = de ? pixel_data_i : 24'h0;
  assign frame_start_o = run_q && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Bench for lcd_timing_driver: a default 480x272 instance (line-level
// timing, request lead and data path), an 800x480 instance (constants,
// line length, sync widths) and a tiny active-high-sync instance
// (frame-level counts and mid-frame reset).
module tb_lcd_timing_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_s;
  int   t;
  int   n_tot = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  // ---------------- default 480x272 ----------------
  logic [23:0] pix0, rgb0;
  logic [10:0] x0, y0, hd0, vd0;
  logic        req0, hs0, vs0, de0, bl0, fs0;

  always_ff @(posedge clk) pix0 <= {13'b0, x0};

  lcd_timing_driver u_d0 (
    .lcd_pclk(clk), .rst_n(rst_n), .pixel_data_i(pix0),
    .pixel_xpos_o(x0), .pixel_ypos_o(y0), .data_req_o(req0),
    .h_disp_o(hd0), .v_disp_o(vd0), .lcd_hs_o(hs0), .lcd_vs_o(vs0),
    .lcd_de_o(de0), .lcd_rgb_o(rgb0), .lcd_bl_o(bl0), .frame_start_o(fs0)
  );

  // ---------------- 800x480 override ----------------
  logic [23:0] rgb2;
  logic [10:0] x2, y2, hd2, vd2;
  logic        req2, hs2, vs2, de2, bl2, fs2;

  lcd_timing_driver #(
    .H_SYNC(128), .H_BACK(88), .H_DISP(800), .H_FRONT(40),
    .V_SYNC(2), .V_BACK(33), .V_DISP(480), .V_FRONT(10)
  ) u_d2 (
    .lcd_pclk(clk), .rst_n(rst_n), .pixel_data_i(24'h0),
    .pixel_xpos_o(x2), .pixel_ypos_o(y2), .data_req_o(req2),
    .h_disp_o(hd2), .v_disp_o(vd2), .lcd_hs_o(hs2), .lcd_vs_o(vs2),
    .lcd_de_o(de2), .lcd_rgb_o(rgb2), .lcd_bl_o(bl2), .frame_start_o(fs2)
  );

  // Edge times of the 800x480 syncs, in monitor cycles.
  int mc = 0, nf = 0, hr = 0, vf = 0, vr = 0;
  int hf[2] = '{0, 0};
  logic hs2_p = 1'b1, vs2_p = 1'b1;

  always @(negedge clk) begin
    mc++;
    if (hs2_p && !hs2) begin
      if (nf < 2) hf[nf] = mc;
      nf++;
    end
    if (!hs2_p && hs2 && nf == 1 && hr == 0) hr = mc;
    if (vs2_p && !vs2 && vf == 0) vf = mc;
    if (!vs2_p && vs2 && vf != 0 && vr == 0) vr = mc;
    hs2_p = hs2;
    vs2_p = vs2;
  end

  // ---------------- tiny panel, active-high syncs ----------------
  // H: 4+2+8+2 = 16 (DE at h 6..13), V: 2+1+4+1 = 8 (rows 3..6), frame 128.
  logic [23:0] pixs, rgbs;
  logic [10:0] xs, ys, hds, vds;
  logic        reqs, hss, vss, des, bls, fss;

  always_ff @(posedge clk) pixs <= {13'b0, xs};

  lcd_timing_driver #(
    .H_SYNC(4), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(1), .V_DISP(4), .V_FRONT(1), .SYNC_POL(1'b1)
  ) u_ds (
    .lcd_pclk(clk), .rst_n(rst_s), .pixel_data_i(pixs),
    .pixel_xpos_o(xs), .pixel_ypos_o(ys), .data_req_o(reqs),
    .h_disp_o(hds), .v_disp_o(vds), .lcd_hs_o(hss), .lcd_vs_o(vss),
    .lcd_de_o(des), .lcd_rgb_o(rgbs), .lcd_bl_o(bls), .frame_start_o(fss)
  );

  initial begin
    int cnt, n, vs_cnt, de_cnt, de_rise, fs_n, fs_t, run, mx, mn;
    logic prev, prev_de, seen;

    rst_n = 1'b0;
    rst_s = 1'b0;
    t = 0;
    repeat (5) @(negedge clk);

    // reset state
    chk("rst_hs", hs0, 1);
    chk("rst_vs", vs0, 1);
    chk("rst_de", de0, 0);
    chk("rst_bl", bl0, 0);
    chk("rst_req", req0, 0);
    chk("rst_fs", fs0, 0);
    chk("rst_rgb", rgb0, 0);
    chk("rst_x", x0, 0);
    chk("h_disp", hd0, 480);
    chk("v_disp", vd0, 272);
    chk("h_disp800", hd2, 800);
    chk("v_disp800", vd2, 480);
    chk("s_rst_hs", hss, 0);
    chk("s_rst_vs", vss, 0);

    // one blank cycle after release
    rst_n = 1'b1;
    #1;
    chk("blank_bl", bl0, 0);
    chk("blank_hs", hs0, 1);

    @(negedge clk);
    t = 0;
    chk("run_bl", bl0, 1);
    chk("run_hs", hs0, 0);
    chk("run_vs", vs0, 0);
    chk("run_fs", fs0, 1);
    chk("run_de", de0, 0);

    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (!hs0) cnt++;
      step();
    end
    chk("hs_width", cnt, 41);

    prev = hs0;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      step();
      if (prev && !hs0) seen = 1'b1;
      prev = hs0;
    end
    chk("line_period", t, 525);
    chk("fs_line1", fs0, 0);

    while (t < 6300) begin
      step();
      if (t == 5249) chk("vs_last_low", vs0, 0);
      if (t == 5250) chk("vs_rise", vs0, 1);
    end

    // first active line (v=12), cycle by cycle
    for (int h = 0; h < 525; h++) begin
      if (h > 0) step();
      chk($sformatf("de_h%0d", h), de0, (h >= 43 && h < 523) ? 1 : 0);
      chk($sformatf("req_h%0d", h), req0, (h >= 42 && h < 522) ? 1 : 0);
      chk($sformatf("x_h%0d", h), x0, (h >= 42 && h < 522) ? h - 42 : 0);
      chk($sformatf("y_h%0d", h), y0, 0);
      chk($sformatf("rgb_h%0d", h), rgb0, (h >= 43 && h < 523) ? h - 43 : 0);
    end

    repeat (43) step();
    chk("l13_req", req0, 1);
    chk("l13_x", x0, 0);
    chk("l13_y", y0, 1);

    // 800x480 edges recorded by the monitor
    chk("w_line", hf[1] - hf[0], 1056);
    chk("w_hs_width", hr - hf[0], 128);
    chk("w_vs_width", vr - vf, 2 * 1056);

    // ---------------- tiny panel frame checks ----------------
    @(negedge clk);
    rst_s = 1'b1;
    #1;
    chk("s_blank_bl", bls, 0);
    chk("s_blank_fs", fss, 0);
    @(negedge clk);
    chk("s_fs0", fss, 1);
    chk("s_hs0", hss, 1);

    vs_cnt = 0; de_cnt = 0; de_rise = 0; fs_n = 0; fs_t = 0;
    run = 0; mx = 0; mn = 999; prev_de = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 128) begin
        if (vss) vs_cnt++;
        if (des) de_cnt++;
        if (des && !prev_de) de_rise++;
      end
      if (des) run++;
      else if (prev_de) begin
        if (run > mx) mx = run;
        if (run < mn) mn = run;
        run = 0;
      end
      if (fss) begin
        fs_n++;
        if (i > 0 && fs_t == 0) fs_t = i;
      end
      prev_de = des;
    end
    chk("s_vs_width", vs_cnt, 32);
    chk("s_de_cycles", de_cnt, 32);
    chk("s_de_bursts", de_rise, 4);
    chk("s_burst_max", mx, 8);
    chk("s_burst_min", mn, 8);
    chk("s_fs_count", fs_n, 2);
    chk("s_frame", fs_t, 128);

    // mid-frame reset at v=3, h=7 of the third frame (t=311)
    repeat (56) @(negedge clk);
    chk("s_pre_de", des, 1);
    chk("s_pre_rgb", rgbs, 1);
    rst_s = 1'b0;
    #1;
    chk("s_mid_de", des, 0);
    chk("s_mid_hs", hss, 0);
    chk("s_mid_vs", vss, 0);
    chk("s_mid_bl", bls, 0);
    chk("s_mid_rgb", rgbs, 0);
    chk("s_mid_req", reqs, 0);
    chk("s_mid_x", xs, 0);
    repeat (2) @(negedge clk);
    chk("s_hold_bl", bls, 0);
    rst_s = 1'b1;
    #1;
    chk("s_rel_fs", fss, 0);
    chk("s_rel_bl", bls, 0);
    @(negedge clk);
    chk("s_restart_fs", fss, 1);
    chk("s_restart_hs", hss, 1);
    chk("s_restart_vs", vss, 1);

    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (fss) seen = 1'b1;
    end
    chk("s_frame_after_rst", n, 128);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
